multi_board: RTL
================

MULTI_BOARD -- requirements
Module: multi_board

Interface
REQ-001 SHALL have parameter NUM_COLORS, default 2: number of ball colours/channels, legal range 2..8.
REQ-002 SHALL have parameter AMOUNT, default 8: initial ball count per colour, legal range 1..255.
REQ-003 SHALL derive local constants CW = max(1, clog2(NUM_COLORS)), DEPTH = NUM_COLORS*AMOUNT, AW = clog2(DEPTH+1), NW = clog2(AMOUNT+1).
REQ-004 SHALL have the port list below, in this order:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- trigger  input  NUM_COLORS  per-colour lever level from board bottom, synchronous to clk.
- refill  input  1  single-cycle request: restock and clear the tray.
- ball_valid  output  1  one-cycle pulse: a ball is released at the top.
- ball_color  output  CW  colour of the released ball; valid while ball_valid=1.
- current_color  output  CW  colour of the ball currently on the board.
- no_balls  output  1  sticky: a trigger hit an empty colour.
- empty_mask  output  NUM_COLORS  bit c=1 when colour c count is 0.
- tray  output  DEPTH*CW  landed-ball record; entry i at bits [i*CW +: CW].
- tray_amount  output  AW  number of valid tray entries.
- tray_full  output  1  tray_amount == DEPTH.

Function
REQ-005 SHALL keep one NW-bit counter per colour, initialised to AMOUNT.
REQ-006 SHALL register trigger into trigger_q every cycle; rise = trigger & ~trigger_q.
REQ-007 SHALL, on multiple simultaneous rises, select the lowest-index rising colour (sel) and ignore all other rises in that cycle.
REQ-008 SHALL implement FSM states IDLE (no ball on board), RUN (ball on board), HALT (out of balls).
REQ-009 SHALL, in IDLE on a rise with count[sel]>0: decrement count[sel], set current_color=sel, pulse ball_valid with ball_color=sel, go to RUN, and write no tray entry.
REQ-010 SHALL, in RUN on a rise: write current_color into tray[tray_amount] and increment tray_amount (saturating at DEPTH), then dispatch as in REQ-009 if count[sel]>0, staying in RUN.
REQ-011 SHALL, in IDLE or RUN on a rise with count[sel]==0: perform the REQ-010 tray write if in RUN, set no_balls=1, emit no ball_valid, and go to HALT.
REQ-012 SHALL ignore all triggers in HALT; no_balls stays 1 until refill or reset.
REQ-013 SHALL, on refill=1 in any state: reload all counters to AMOUNT, clear tray to 0 and tray_amount to 0, clear no_balls, set current_color=0, and go to IDLE.
REQ-014 SHALL give refill priority over any trigger rise in the same cycle; that rise is discarded.
REQ-015 SHALL register ball_valid and ball_color, so ball_valid is high exactly in the cycle after the clock edge that sampled the rise (1-cycle latency); ball_valid is 0 otherwise and ball_color holds its last value.
REQ-016 SHALL update current_color, tray, tray_amount, no_balls and counters on the same edge that samples the rise.
REQ-017 SHALL never decrement a counter below 0 and never write a tray entry at an index >= DEPTH.
REQ-018 SHALL derive empty_mask and tray_full combinationally from the registered counters and tray_amount.

Reset
REQ-019 SHALL, when rst_n=0 at a clk edge, apply REQ-013 values and set state=IDLE, ball_valid=0, ball_color=0, trigger_q=all-ones.
REQ-020 SHALL, because trigger_q resets to all-ones, not treat a trigger held high through reset release as a rise; that colour must go low, then high again.
REQ-021 SHALL let reset asserted mid-operation override refill and all triggers in the same cycle.

Verification
REQ-022 Default params; after reset, pulse trigger[0] -> next cycle ball_valid=1 with ball_color=0, count0=7, tray_amount=0, state RUN.
REQ-023 In RUN with current_color=0, pulse trigger[1] -> tray[1:0]=0, tray_amount=1, ball_valid with ball_color=1, current_color=1.
REQ-024 Raise trigger[0] and trigger[1] in the same cycle -> only colour 0 is dispatched; count1 is unchanged.
REQ-025 Drain colour 0 (8 dispatches), then pulse trigger[0] -> no ball_valid, no_balls=1, empty_mask[0]=1, last ball recorded in tray; further triggers are ignored.
REQ-026 Raise refill and trigger[1] in the same cycle while in HALT -> counters=8, tray_amount=0, no_balls=0, IDLE, no ball_valid.
REQ-027 NUM_COLORS=4, AMOUNT=1: alternate rises over all 4 colours, then rise colour 3 again -> tray_full=1 with tray_amount=4, then no_balls=1.

Source files
------------

// File: rtl/multi_board.sv
// Ball board: per-colour ball stock, lever-triggered dispatch,
// and a tray recording the colour of every ball that lands.
module multi_board #(
  parameter int NUM_COLORS = 2,
  parameter int AMOUNT = 8,
  localparam int CW = (NUM_COLORS > 2) ? $clog2(NUM_COLORS) : 1,
  localparam int DEPTH = NUM_COLORS * AMOUNT,
  localparam int AW = $clog2(DEPTH + 1),
  localparam int NW = $clog2(AMOUNT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_COLORS-1:0] trigger,
  input  logic                  refill,
  output logic                  ball_valid,
  output logic [CW-1:0]         ball_color,
  output logic [CW-1:0]         current_color,
  output logic                  no_balls,
  output logic [NUM_COLORS-1:0] empty_mask,
  output logic [DEPTH*CW-1:0]   tray,
  output logic [AW-1:0]         tray_amount,
  output logic                  tray_full
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [NUM_COLORS-1:0] trigger_q;
  logic [NUM_COLORS-1:0] rise;
  logic [NW-1:0]         count [NUM_COLORS];
  logic [CW-1:0]         sel;
  logic                  any_rise;
  logic                  has_ball;
  logic                  dispatch;
  logic                  store;
  logic                  halt_hit;

  assign rise     = trigger & ~trigger_q;
  assign any_rise = |rise;
  assign has_ball = count[sel] != '0;

  // Lowest-index rising colour wins
  always_comb begin
    sel = '0;
    for (int i = NUM_COLORS - 1; i >= 0; i--) begin
      if (rise[i]) sel = CW'(i);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; refill overrides any rise
  always_comb begin
    state_nx = state;
    if (refill) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE, RUN: if (any_rise) state_nx = has_ball ? RUN : HALT;
        HALT:      state_nx = HALT;
        default:   state_nx = IDLE;
      endcase
    end
  end

  // Per-cycle actions derived from state and the selected rise
  always_comb begin
    dispatch = 1'b0;
    store    = 1'b0;
    halt_hit = 1'b0;
    if (!refill && any_rise && state != HALT) begin
      store    = state == RUN;
      dispatch = has_ball;
      halt_hit = !has_ball;
    end
  end

  // Datapath: trigger history, stock, tray and released-ball outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trigger_q     <= '1;
      ball_valid    <= 1'b0;
      ball_color    <= '0;
      current_color <= '0;
      no_balls      <= 1'b0;
      tray          <= '0;
      tray_amount   <= '0;
      for (int c = 0; c < NUM_COLORS; c++) count[c] <= NW'(AMOUNT);
    end else begin
      trigger_q  <= trigger;
      ball_valid <= dispatch;
      if (refill) begin
        current_color <= '0;
        no_balls      <= 1'b0;
        tray          <= '0;
        tray_amount   <= '0;
        for (int c = 0; c < NUM_COLORS; c++) count[c] <= NW'(AMOUNT);
      end else begin
        if (store && tray_amount < AW'(DEPTH)) begin
          tray[int'(tray_amount)*CW +: CW] <= current_color;
          tray_amount <= tray_amount + AW'(1);
        end
        if (dispatch) begin
          count[sel]    <= count[sel] - NW'(1);
          current_color <= sel;
          ball_color    <= sel;
        end
        if (halt_hit) no_balls <= 1'b1;
      end
    end
  end

  // Status flags straight from registered state
  always_comb begin
    for (int c = 0; c < NUM_COLORS; c++) empty_mask[c] = count[c] == '0;
  end

  assign tray_full = tray_amount == AW'(DEPTH);

endmodule
